// File: rtl/hack_alu_issue_pkg.sv
// rtl/hack_alu_issue_pkg.sv - Hack instruction field positions and issue-stage FSM states
package hack_alu_issue_pkg;

   localparam int unsigned BIT_CINSTR = 15;
   localparam int unsigned BIT_A      = 12;
   localparam int unsigned COMP_HI    = 11;
   localparam int unsigned COMP_LO    = 6;
   localparam int unsigned DEST_A     = 2;
   localparam int unsigned DEST_D     = 1;
   localparam int unsigned DEST_M     = 0;
   localparam int unsigned JMP_LT     = 2;
   localparam int unsigned JMP_EQ     = 1;
   localparam int unsigned JMP_GT     = 0;

   // RET retires single-cycle work: A-instructions and trapped C-instructions
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MRD  = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      RET  = 3'd4
   } state_t;

endpackage

// File: rtl/hack_alu_issue_jump_eval.sv
// rtl/hack_alu_issue_jump_eval.sv - Hack jump condition evaluator (jump[2:0]=LT,EQ,GT vs ALU flags)
module hack_jump_eval
   import hack_alu_issue_pkg::*;
(
   input  logic [2:0] i_jump,
   input  logic       i_zr,
   input  logic       i_ng,
   output logic       o_taken
);

   assign o_taken = (i_jump[JMP_LT] & i_ng)
                  | (i_jump[JMP_EQ] & i_zr)
                  | (i_jump[JMP_GT] & ~i_zr & ~i_ng);

endmodule

// File: rtl/hack_alu_issue.sv
// rtl/hack_alu_issue.sv - multi-cycle Hack issue stage owning A/D, driving the ALU and resolving jumps
// Optional macro HACK_ILLEGAL_TRAP_EN: trap C-instructions whose instr[14:13] != 2'b11.
module hack_alu_issue
   import hack_alu_issue_pkg::*;
#(
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic        alu_zx,
   output logic        alu_nx,
   output logic        alu_zy,
   output logic        alu_ny,
   output logic        alu_f,
   output logic        alu_no,
   input  logic [15:0] alu_out,
   input  logic        alu_zr,
   input  logic        alu_ng,
   output logic        retire,
   output logic        jump_taken,
   output logic [15:0] jump_addr,
   output logic        err_timeout,
   output logic [15:0] a_reg,
   output logic [15:0] d_reg
`ifdef HACK_ILLEGAL_TRAP_EN
   ,
   output logic        illegal
`endif
);

   localparam logic [15:0] RD_LAST = 16'(RD_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_a;
   logic [15:0] r_d;
   logic [15:0] r_a_old;
   logic [5:0]  r_comp;
   logic [2:0]  r_dest;
   logic [2:0]  r_jump;
   logic [15:0] r_alu_x;
   logic [15:0] r_alu_y;
   logic [5:0]  r_alu_ctrl;
   logic [15:0] r_res;
   logic        r_zr;
   logic        r_ng;
   logic [15:0] r_rd_cnt;

   logic        w_accept;
   logic        w_is_c;
   logic        w_illegal;
   logic        w_rd_expire;
   logic        w_load_exec;
   logic        w_taken;

   assign instr_ready = ~reset & (r_state == IDLE);
   assign w_accept    = instr_valid & instr_ready;
   assign w_is_c      = instr[BIT_CINSTR];

`ifdef HACK_ILLEGAL_TRAP_EN
   logic r_trap;
   assign w_illegal = w_is_c & (instr[14:13] != 2'b11);
   assign illegal   = ~reset & (r_state == RET) & r_trap;
`else
   assign w_illegal = 1'b0;
`endif

   assign w_rd_expire = ~mem_rvalid & (r_rd_cnt == RD_LAST);
   // Operands are captured once on EXEC entry so they stay put for the whole ALU cycle
   assign w_load_exec = (w_accept & w_is_c & ~w_illegal & ~instr[BIT_A])
                      | ((r_state == MRD) & mem_rvalid);

   hack_jump_eval u_jump_eval (
      .i_jump  (r_jump),
      .i_zr    (r_zr),
      .i_ng    (r_ng),
      .o_taken (w_taken)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (!w_is_c || w_illegal) w_state_nxt = RET;
               else if (instr[BIT_A])    w_state_nxt = MRD;
               else                      w_state_nxt = EXEC;
            end
         end
         MRD: begin
            if (mem_rvalid)       w_state_nxt = EXEC;
            else if (w_rd_expire) w_state_nxt = IDLE;
         end
         EXEC:    w_state_nxt = WB;
         WB:      w_state_nxt = IDLE;
         RET:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_d        <= '0;
         r_a_old    <= '0;
         r_comp     <= '0;
         r_dest     <= '0;
         r_jump     <= '0;
         r_alu_x    <= '0;
         r_alu_y    <= '0;
         r_alu_ctrl <= '0;
         r_res      <= '0;
         r_zr       <= 1'b0;
         r_ng       <= 1'b0;
         r_rd_cnt   <= '0;
`ifdef HACK_ILLEGAL_TRAP_EN
         r_trap     <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a_old  <= r_a;
            r_comp   <= instr[COMP_HI:COMP_LO];
            r_dest   <= instr[5:3];
            r_jump   <= instr[2:0];
            r_rd_cnt <= '0;
`ifdef HACK_ILLEGAL_TRAP_EN
            r_trap   <= w_illegal;
`endif
            if (!w_is_c) r_a <= {1'b0, instr[14:0]};
         end
         if (w_load_exec) begin
            r_alu_x    <= r_d;
            r_alu_y    <= (r_state == MRD) ? mem_rdata : r_a;
            r_alu_ctrl <= (r_state == MRD) ? r_comp : instr[COMP_HI:COMP_LO];
         end
         if ((r_state == MRD) && !mem_rvalid && !w_rd_expire) r_rd_cnt <= r_rd_cnt + 16'd1;
         if (r_state == EXEC) begin
            r_res <= alu_out;
            r_zr  <= alu_zr;
            r_ng  <= alu_ng;
         end
         if (r_state == WB) begin
            if (r_dest[DEST_A]) r_a <= r_res;
            if (r_dest[DEST_D]) r_d <= r_res;
         end
      end
   end

   assign mem_addr    = r_a_old;
   assign mem_rd      = ~reset & (r_state == MRD);
   assign mem_wr      = ~reset & (r_state == WB) & r_dest[DEST_M];
   assign mem_wdata   = r_res;
   assign err_timeout = ~reset & (r_state == MRD) & w_rd_expire;
   assign retire      = ~reset & ((r_state == WB) | (r_state == RET)
                                  | ((r_state == MRD) & w_rd_expire));
   assign jump_taken  = ~reset & (r_state == WB) & w_taken;
   assign jump_addr   = r_a_old;
   assign alu_x       = r_alu_x;
   assign alu_y       = r_alu_y;
   assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_alu_ctrl;
   assign a_reg       = r_a;
   assign d_reg       = r_d;

endmodule
